// File: rtl/aurora_pkg.sv
// Shared types and default parameters for the Aurora simplex init block.
package aurora_pkg;
  localparam int N_LANES_DEF        = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int VERIFY_SEQ_DEF     = 64;
  localparam int RST_HOLD_DEF       = 16;

  typedef enum logic [2:0] {
    OS_IDLE   = 3'd0,
    OS_ALIGN  = 3'd1,
    OS_BOND   = 3'd2,
    OS_VERIFY = 3'd3,
    OS_DATA   = 3'd4
  } os_sel_t;

  typedef enum logic [2:0] {
    RST    = 3'd0,
    ALIGN  = 3'd1,
    BOND   = 3'd2,
    VERIFY = 3'd3,
    READY  = 3'd4
  } init_state_t;

  // Ordered set sent by an active lane in a given state.
  function automatic os_sel_t state_os(init_state_t s);
    case (s)
      ALIGN:   return OS_ALIGN;
      BOND:    return OS_BOND;
      VERIFY:  return OS_VERIFY;
      READY:   return OS_DATA;
      default: return OS_IDLE;
    endcase
  endfunction
endpackage

// File: rtl/aurora_init_timer.sv
// Up-counter with clear and enable; tc is high once the count reaches MAX_CYCLES-1.
module aurora_init_timer #(
  parameter int MAX_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(MAX_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == LAST);
endmodule

// File: rtl/aurora_simplex_init.sv
// Simplex channel bring-up FSM: RST -> ALIGN -> (BOND) -> VERIFY -> READY,
// with per-state timeouts, receiver-requested resets and lane-mask supervision.
module aurora_simplex_init
  import aurora_pkg::*;
#(
  parameter int N_LANES        = N_LANES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int VERIFY_SEQ     = VERIFY_SEQ_DEF,
  parameter int RST_HOLD       = RST_HOLD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  single_lane,
  input  logic [N_LANES-1:0]    lane_select,
  input  logic                  simplex_aligned,
  input  logic                  simplex_bonded,
  input  logic                  simplex_verified,
  input  logic                  simplex_reset,
  input  logic                  tx_ready,
  output os_sel_t [N_LANES-1:0] os_sel,
  output logic [N_LANES-1:0]    lane_active,
  output logic                  channel_up,
  output init_state_t           init_state,
  output logic                  timeout_err,
  output logic [7:0]            retry_cnt
);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int VER_W  = $clog2(VERIFY_SEQ + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [VER_W-1:0]  VER_DONE  = VER_W'(VERIFY_SEQ);

  init_state_t           state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [VER_W-1:0]      ver_q, ver_d;
  logic [N_LANES-1:0]    sel_q, sel_d;
  logic                  single_q, single_d;
  logic [N_LANES-1:0]    lane_active_q, lane_active_d;
  os_sel_t [N_LANES-1:0] os_sel_q, os_sel_d;
  logic                  channel_up_q, channel_up_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [7:0]            retry_q, retry_d;

  logic [N_LANES-1:0] eff_mask;
  logic               found;
  logic               mask_changed, state_change;
  logic               timer_clr, timer_en, timer_tc;

  always_comb begin
    eff_mask = lane_select;
    found    = 1'b0;
    if (single_lane) begin
      eff_mask = '0;
      for (int i = 0; i < N_LANES; i++) begin
        if (lane_select[i] && !found) begin
          eff_mask[i] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

  // Raw select/mode are latched so a change is seen even if the effective mask is unchanged.
  assign mask_changed = (lane_select != sel_q) || (single_lane != single_q);

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    single_d      = single_q;
    lane_active_d = lane_active_q;
    timeout_err_d = 1'b0;
    retry_d       = retry_q;
    if (state_q == RST) begin
      if ((hold_q == HOLD_LAST) && (eff_mask != '0)) begin
        state_d       = ALIGN;
        sel_d         = lane_select;
        single_d      = single_lane;
        lane_active_d = eff_mask;
      end
    end else if (simplex_reset || mask_changed) begin
      state_d = RST;
    end else begin
      case (state_q)
        ALIGN:   if (simplex_aligned)
                   state_d = (single_q || ($countones(lane_active_q) == 1)) ? VERIFY : BOND;
        BOND:    if (simplex_bonded) state_d = VERIFY;
        VERIFY:  if ((ver_q == VER_DONE) && simplex_verified) state_d = READY;
        default: ;
      endcase
      if ((state_d == state_q) && (state_q != READY) && timer_tc) begin
        state_d       = RST;
        timeout_err_d = 1'b1;
        if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
      end
    end
  end

  assign state_change = (state_d != state_q);

  always_comb begin
    hold_d = hold_q;
    ver_d  = ver_q;
    if (state_change) begin
      hold_d = '0;
      ver_d  = '0;
    end else begin
      if ((state_q == RST) && (hold_q != HOLD_LAST)) hold_d = hold_q + 1'b1;
      if ((state_q == VERIFY) && tx_ready && (ver_q != VER_DONE)) ver_d = ver_q + 1'b1;
    end
  end

  assign timer_clr = state_change || (state_q == RST) || (state_q == READY);
  assign timer_en  = !timer_clr;

  aurora_init_timer #(
    .MAX_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (timer_en),
    .tc  (timer_tc)
  );

  // Outputs are computed from the next state so they line up with init_state.
  always_comb begin
    channel_up_d = (state_d == READY);
    for (int i = 0; i < N_LANES; i++) begin
      os_sel_d[i] = lane_active_d[i] ? state_os(state_d) : OS_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RST;
      hold_q        <= '0;
      ver_q         <= '0;
      sel_q         <= '0;
      single_q      <= 1'b0;
      lane_active_q <= '0;
      channel_up_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      retry_q       <= '0;
      for (int i = 0; i < N_LANES; i++) os_sel_q[i] <= OS_IDLE;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      ver_q         <= ver_d;
      sel_q         <= sel_d;
      single_q      <= single_d;
      lane_active_q <= lane_active_d;
      channel_up_q  <= channel_up_d;
      timeout_err_q <= timeout_err_d;
      retry_q       <= retry_d;
      os_sel_q      <= os_sel_d;
    end
  end

  assign init_state  = state_q;
  assign os_sel      = os_sel_q;
  assign lane_active = lane_active_q;
  assign channel_up  = channel_up_q;
  assign timeout_err = timeout_err_q;
  assign retry_cnt   = retry_q;
endmodule

// File: tb/tb_aurora_simplex_init.sv
// Scoreboard bench for aurora_simplex_init: a behavioural model predicts every
// cycle's outputs into a queue, and a monitor pops and compares after each edge.
module tb_aurora_simplex_init;
  import aurora_pkg::*;

  localparam int NL = 4;
  localparam int TO = 160;
  localparam int VS = 64;
  localparam int RH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic single_lane = 1'b0;
  logic [NL-1:0] lane_select = '0;
  logic simplex_aligned = 1'b0, simplex_bonded = 1'b0, simplex_verified = 1'b0;
  logic simplex_reset = 1'b0, tx_ready = 1'b0;
  os_sel_t [NL-1:0] os_sel;
  logic [NL-1:0] lane_active;
  logic channel_up;
  init_state_t init_state;
  logic timeout_err;
  logic [7:0] retry_cnt;

  aurora_simplex_init #(
    .N_LANES(NL), .TIMEOUT_CYCLES(TO), .VERIFY_SEQ(VS), .RST_HOLD(RH)
  ) dut (
    .clk(clk), .rst(rst), .single_lane(single_lane), .lane_select(lane_select),
    .simplex_aligned(simplex_aligned), .simplex_bonded(simplex_bonded),
    .simplex_verified(simplex_verified), .simplex_reset(simplex_reset),
    .tx_ready(tx_ready), .os_sel(os_sel), .lane_active(lane_active),
    .channel_up(channel_up), .init_state(init_state), .timeout_err(timeout_err),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    init_state_t      st;
    os_sel_t [NL-1:0] os;
    logic [NL-1:0]    la;
    logic             cu;
    logic             err;
    logic [7:0]       retry;
  } exp_t;

  exp_t q[$];
  init_state_t trace[$];
  int n_checks = 0;
  int n_fail = 0;
  int err_cycles = 0;
  bit saw_bond = 1'b0;

  // requested inputs, applied at the next falling edge
  logic r_rst = 1'b0, r_single = 1'b0, r_al = 1'b0, r_bo = 1'b0, r_ve = 1'b0;
  logic r_sr = 1'b0, r_tx = 1'b0;
  logic [NL-1:0] r_sel = '0;
  bit rnd_tx = 1'b0, rnd_all = 1'b0;

  // model state
  init_state_t m_st = RST;
  int m_age = 0, m_acc = 0, m_retry = 0;
  logic [NL-1:0] m_la = '0, m_sel = '0;
  logic m_single = 1'b0, m_err = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic os_sel_t os_for(init_state_t s);
    case (s)
      ALIGN:   return OS_ALIGN;
      BOND:    return OS_BOND;
      VERIFY:  return OS_VERIFY;
      READY:   return OS_DATA;
      default: return OS_IDLE;
    endcase
  endfunction

  // Predicts the outputs visible after the coming rising edge.
  task automatic model_step();
    init_state_t nx;
    logic [NL-1:0] eff;
    exp_t e;
    if (rst) begin
      m_st = RST; m_age = 0; m_acc = 0; m_la = '0; m_sel = '0;
      m_single = 1'b0; m_retry = 0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      nx = m_st;
      if (m_st == RST) begin
        eff = single_lane ? (lane_select & (~lane_select + 1'b1)) : lane_select;
        if (m_age >= RH - 1 && eff != 0) begin
          nx = ALIGN; m_la = eff; m_sel = lane_select; m_single = single_lane;
        end
      end else if (simplex_reset) nx = RST;
      else if (lane_select != m_sel || single_lane != m_single) nx = RST;
      else if (m_st == ALIGN && simplex_aligned)
        nx = (m_single || $countones(m_la) == 1) ? VERIFY : BOND;
      else if (m_st == BOND && simplex_bonded) nx = VERIFY;
      else if (m_st == VERIFY && m_acc == VS && simplex_verified) nx = READY;
      else if (m_st != READY && m_age == TO - 1) begin
        nx = RST; m_err = 1'b1;
        if (m_retry < 255) m_retry++;
      end
      if (nx != m_st) begin
        m_age = 0; m_acc = 0;
      end else begin
        m_age++;
        if (m_st == VERIFY && tx_ready && m_acc < VS) m_acc++;
      end
      m_st = nx;
    end
    e.st = m_st;
    for (int i = 0; i < NL; i++) e.os[i] = m_la[i] ? os_for(m_st) : OS_IDLE;
    e.la = m_la;
    e.cu = (m_st == READY);
    e.err = m_err;
    e.retry = 8'(m_retry);
    q.push_back(e);
  endtask

  task automatic run(int n);
    logic prev;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rnd_all) begin
        r_rst = rst ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 699) == 0);
        r_sr  = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 499) == 0) r_sel = NL'($urandom_range(0, 15));
        if ($urandom_range(0, 599) == 0) r_single = ~r_single;
        r_al = ($urandom_range(0, 19) == 0);
        r_bo = ($urandom_range(0, 19) == 0);
        r_ve = 1'($urandom_range(0, 1));
        r_tx = 1'($urandom_range(0, 1));
      end
      prev = rst;
      rst = r_rst;
      single_lane = r_single;
      lane_select = r_sel;
      simplex_aligned = r_al;
      simplex_bonded = r_bo;
      simplex_verified = r_ve;
      simplex_reset = r_sr;
      tx_ready = rnd_tx ? ~tx_ready : r_tx;
      if (rst && !prev) begin
        #1;
        chk("async_rst_state", init_state, RST);
        chk("async_rst_os_sel", os_sel, '0);
        chk("async_rst_lane_active", lane_active, '0);
        chk("async_rst_channel_up", channel_up, 1'b0);
        chk("async_rst_timeout_err", timeout_err, 1'b0);
        chk("async_rst_retry", retry_cnt, 8'd0);
      end
      model_step();
    end
  endtask

  task automatic wait_state(init_state_t s, int max, string name);
    int k = 0;
    while (init_state != s && k < max) begin
      run(1);
      k++;
    end
    chk(name, init_state, s);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (init_state == BOND) saw_bond = 1'b1;
      if (timeout_err) err_cycles++;
      if (trace.size() == 0 || trace[$] != init_state) trace.push_back(init_state);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("init_state", init_state, e.st);
        chk("os_sel", os_sel, e.os);
        chk("lane_active", lane_active, e.la);
        chk("channel_up", channel_up, e.cu);
        chk("timeout_err", timeout_err, e.err);
        chk("retry_cnt", retry_cnt, e.retry);
      end
    end
  end

  initial begin
    os_sel_t [NL-1:0] all_data;
    init_state_t seq [4] = '{ALIGN, BOND, VERIFY, READY};
    for (int i = 0; i < NL; i++) all_data[i] = OS_DATA;

    // reset, then single-lane bring-up with aligned at cycle 30
    r_rst = 1'b1; r_single = 1'b1; r_sel = 4'b0110; r_tx = 1'b1; r_ve = 1'b1;
    run(3);
    r_rst = 1'b0;
    run(30);
    r_al = 1'b1;
    run(100);
    chk("single_lane_active", lane_active, 4'b0010);
    chk("single_channel_up", channel_up, 1'b1);
    chk("single_no_bond", saw_bond, 1'b0);

    // simplex_reset in READY together with aligned
    r_sr = 1'b1; run(1); r_sr = 1'b0; r_al = 1'b0; run(1);
    chk("sreset_ready_state", init_state, RST);
    chk("sreset_ready_cu", channel_up, 1'b0);
    chk("sreset_ready_retry", retry_cnt, 8'd0);

    // simplex_reset and aligned in the same ALIGN cycle
    wait_state(ALIGN, 100, "wait_align_a");
    r_al = 1'b1; r_sr = 1'b1; run(1); r_al = 1'b0; r_sr = 1'b0; run(1);
    chk("sreset_beats_aligned", init_state, RST);

    // four-lane bring-up
    r_single = 1'b0; r_sel = 4'b1111;
    trace.delete();
    wait_state(ALIGN, 100, "wait_align_b");
    run(5);
    r_al = 1'b1; run(1); r_al = 1'b0;
    run(10);
    r_bo = 1'b1; run(1); r_bo = 1'b0;
    wait_state(READY, 300, "wait_ready_4lane");
    while (trace.size() > 0 && trace[0] == RST) void'(trace.pop_front());
    chk("trace_len", trace.size(), 4);
    for (int i = 0; i < 4 && i < trace.size(); i++) chk("trace_seq", trace[i], seq[i]);
    chk("four_lane_data", os_sel, all_data);

    // BOND timeout
    r_sr = 1'b1; run(1); r_sr = 1'b0;
    wait_state(ALIGN, 100, "wait_align_c");
    r_al = 1'b1; run(1); r_al = 1'b0;
    wait_state(BOND, 5, "wait_bond_c");
    err_cycles = 0;
    run(TO + 3);
    chk("timeout_pulse_cycles", err_cycles, 1);
    chk("timeout_retry_one", retry_cnt, 8'd1);

    // repeated ALIGN timeouts saturate retry_cnt
    run(300 * (RH + TO));
    chk("retry_saturated", retry_cnt, 8'd255);

    // empty lane mask keeps the block in RST
    r_rst = 1'b1; run(2);
    r_sel = '0; r_rst = 1'b0;
    run(200);
    chk("zero_mask_state", init_state, RST);
    chk("zero_mask_os_sel", os_sel, '0);

    // lane_select change in VERIFY re-latches the mask
    r_sel = 4'b0011; r_tx = 1'b0;
    wait_state(ALIGN, 50, "wait_align_d");
    r_al = 1'b1; run(1); r_al = 1'b0;
    wait_state(BOND, 5, "wait_bond_d");
    r_bo = 1'b1; run(1); r_bo = 1'b0;
    wait_state(VERIFY, 5, "wait_verify_d");
    run(5);
    r_sel = 4'b1100; run(1); run(1);
    chk("mask_change_state", init_state, RST);
    wait_state(ALIGN, 50, "wait_align_e");
    chk("relatched_mask", lane_active, 4'b1100);

    // toggling tx_ready in VERIFY
    r_al = 1'b1; run(1); r_al = 1'b0;
    wait_state(BOND, 5, "wait_bond_f");
    r_bo = 1'b1; run(1); r_bo = 1'b0;
    wait_state(VERIFY, 5, "wait_verify_f");
    rnd_tx = 1'b1;
    wait_state(READY, 400, "wait_ready_toggle");
    rnd_tx = 1'b0;
    chk("toggle_channel_up", channel_up, 1'b1);

    // rst asserted mid-VERIFY
    r_sr = 1'b1; run(1); r_sr = 1'b0;
    wait_state(ALIGN, 100, "wait_align_g");
    r_al = 1'b1; run(1); r_al = 1'b0;
    wait_state(BOND, 5, "wait_bond_g");
    r_bo = 1'b1; run(1); r_bo = 1'b0;
    wait_state(VERIFY, 5, "wait_verify_g");
    run(10);
    r_rst = 1'b1; run(3);
    r_rst = 1'b0; run(3);

    // random traffic
    rnd_all = 1'b1;
    run(3000);
    rnd_all = 1'b0;
    r_rst = 1'b0; r_sr = 1'b0;
    run(3);

    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
